// File: rtl/etapa_id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: default widths, the
// control bundle layout and the all-zero bubble constant.
package etapa_id_ex_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;
    localparam int ALUOP_W_DEF = 3;
    localparam int CNT_W_DEF   = 16;
    localparam int REG_ZERO    = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    // A bubble is an instruction with every control bit cleared.
    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/etapa_id_ex_deteccion_riesgos.sv
// Load-use hazard comparator: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle freeze of PC and IF/ID.
module deteccion_riesgos
    import etapa_id_ex_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard,
    output logic             pc_write,
    output logic             if_id_write
);

    // id_rt is compared even for instructions that do not read it; the
    // occasional spurious stall is cheaper than decoding operand usage here.
    assign hazard = ex_mem_read
                  & (ex_rt != REG_W'(REG_ZERO))
                  & ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign pc_write    = ~hazard;
    assign if_id_write = ~hazard;

endmodule

// File: rtl/etapa_id_ex.sv
// ID/EX pipeline register with built-in load-use stall, flush squashing and a
// saturating stall-cycle counter.
module etapa_id_ex
    import etapa_id_ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int ALUOP_W = ALUOP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  id_pc4,
    input  logic [DATA_W-1:0]  id_da,
    input  logic [DATA_W-1:0]  id_db,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_reg_write,
    input  logic               id_mem_to_reg,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic               id_reg_dst,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               flush,
    output logic [DATA_W-1:0]  ex_pc4,
    output logic [DATA_W-1:0]  ex_da,
    output logic [DATA_W-1:0]  ex_db,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_alu_src,
    output logic               ex_reg_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               pc_write,
    output logic               if_id_write,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic  hazard;
    logic  bubble;
    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    deteccion_riesgos #(
        .REG_W (REG_W)
    ) u_deteccion_riesgos (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .hazard      (hazard),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    assign id_ctrl = '{reg_write:  id_reg_write,
                       mem_to_reg: id_mem_to_reg,
                       mem_read:   id_mem_read,
                       mem_write:  id_mem_write,
                       alu_src:    id_alu_src,
                       reg_dst:    id_reg_dst};

    assign bubble = flush | hazard;

    // Bubbles clear register numbers too, so forwarding and the next hazard
    // check see nothing to match against.
    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            ex_pc4    <= '0;
            ex_da     <= '0;
            ex_db     <= '0;
            ex_imm    <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_rd     <= '0;
            ex_ctrl   <= CTRL_NOP;
            ex_alu_op <= '0;
        end else begin
            ex_pc4    <= id_pc4;
            ex_da     <= id_da;
            ex_db     <= id_db;
            ex_imm    <= id_imm;
            ex_rs     <= id_rs;
            ex_rt     <= id_rt;
            ex_rd     <= id_rd;
            ex_ctrl   <= id_ctrl;
            ex_alu_op <= id_alu_op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_reg_dst    = ex_ctrl.reg_dst;

endmodule

// File: doc/etapa_id_ex.md
Name: etapa_id_ex

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline, with load-use hazard detection built in.
- Captures decoded operands, register numbers and control from Decode and presents them to Execute one cycle later.
- Its registered Rs/Rt and reg_write bit feed the forwarding unit in EX.
- On a load-use hazard it freezes PC and IF/ID and inserts a bubble. On a branch flush it squashes the entry.
- Keeps a saturating count of stall cycles for performance readout.

Parameters:
DATA_W, 32, operand/immediate/PC width
REG_W, 5, register-number width
ALUOP_W, 3, ALU operation code width
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  synchronous, active-high
id_pc4  in  DATA_W  PC+4 from Decode
id_da  in  DATA_W  register file read data port A (Rs)
id_db  in  DATA_W  register file read data port B (Rt)
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_W each  register numbers decoded in ID
id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_reg_dst  in  1 each  control bits from decoder
id_alu_op  in  ALUOP_W  ALU operation
flush  in  1  branch/jump taken in EX; squash the instruction now in ID
ex_pc4, ex_da, ex_db, ex_imm  out  DATA_W  registered operands to EX
ex_rs, ex_rt, ex_rd  out  REG_W  registered register numbers (Rs/Rt go to the forwarding unit)
ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_dst  out  1  registered control
ex_alu_op  out  ALUOP_W  registered ALU op
pc_write  out  1  0 freezes PC
if_id_write  out  1  0 freezes IF/ID register
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (synchronous, active-high): all ex_* outputs are 0, which is a NOP bubble. stall_cnt is 0.
- Hazard (combinational, from current registered state and ID inputs): hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - Compare id_rt even when the ID instruction does not read Rt. The conservative stall is accepted.
- pc_write = if_id_write = ~hazard. These are combinational.
  - During reset they still follow the hazard equation. The outputs are 0 in reset, so hazard is 0.
- Next-state priority, evaluated every rising edge:
  1. reset: clear everything.
  2. flush: load a bubble. All control bits are 0; data and register-number fields are 0. flush wins over hazard.
  3. hazard: load a bubble (same as flush). pc_write/if_id_write hold IF/ID, so the ID instruction is re-presented next cycle.
  4. otherwise: load all id_* fields into the ex_* registers.
- Latency: one cycle from id_* to ex_*.
- A bubble zeroes ex_rs/ex_rt. This keeps the forwarding unit and the next hazard check quiet.
- A stall lasts exactly one cycle: after the bubble, ex_mem_read is 0, so hazard drops.
- Back-to-back loads: each dependent consumer still gets exactly one bubble.
- stall_cnt:
  - Increments on every edge where hazard = 1 and reset = 0, including when flush also fires.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Reset asserted mid-stall: the next state is a bubble with counter 0. No pending stall survives reset.

Decomposition:
- Shared package: NOP/bubble control constant (all zero), ALUOP_W, REG_W, DATA_W defaults, REG_ZERO = 0.
- One natural sub-module: deteccion_riesgos, the combinational load-use comparator producing hazard, pc_write and if_id_write. The rest is the pipeline register and the counter.

Test Plan:
- Pass-through: id_rs=3, id_rt=4, id_rd=5, id_da=32'h11, id_reg_write=1, no hazard. Next cycle ex_rs=3, ex_rt=4, ex_rd=5, ex_da=32'h11, ex_reg_write=1; pc_write=1.
- Load-use: EX holds lw with ex_rt=8, ex_mem_read=1; ID has id_rs=8. Expect pc_write=if_id_write=0 that cycle. Next cycle all ex_* control is 0 and stall_cnt=1. The following cycle the held ID instruction loads normally.
- No stall on $zero: ex_mem_read=1, ex_rt=0, id_rs=0. Expect pc_write=1, no bubble, stall_cnt unchanged.
- Flush with hazard: flush=1 while the load-use condition holds. Next state is a bubble and stall_cnt increments by 1. Flush of a non-hazard ID: bubble, counter unchanged.
- Reset mid-stall: assert reset in a hazard cycle. Next cycle all ex_*=0, stall_cnt=0, pc_write=1.
- Counter saturation: preload via 2^CNT_W-1 hazard cycles (CNT_W=4 in bench), then one more hazard. stall_cnt stays 4'hF.
